if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
Parametrised successor to the single-shot IF stage. It owns the fetch PC and issues sequential instruction requests to the memory controller over a req/done handshake. Returned instructions are buffered in a DEPTH-entry prefetch queue, and {pc, inst} pairs are presented to IF/ID with a valid/stall handshake. Branch redirect flushes the queue, and a response already in flight is discarded safely.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
INST_WIDTH, 32, instruction width
DEPTH, 4, prefetch queue entries; power of 2, >= 2
PC_STEP, 4, byte increment between sequential fetches
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
mem_req_o  out  1  fetch request, level, held until mem_done_i
mem_addr_o  out  ADDR_WIDTH  fetch address, stable while mem_req_o=1
mem_done_i  in  1  one-cycle pulse: mem_inst_i valid for current request
mem_inst_i  in  INST_WIDTH  returned instruction
branch_flag_i  in  1  redirect request from EX
branch_target_i  in  ADDR_WIDTH  redirect address
stall_i  in  1  downstream (IF/ID) cannot accept this cycle
if_valid_o  out  1  queue head valid
if_pc_o  out  ADDR_WIDTH  PC of head entry, zero when empty
if_inst_o  out  INST_WIDTH  instruction of head entry, ZeroWord when empty
stall_req_o  out  1  to ctrl; equals !if_valid_o

Behaviour:
- Reset (rst=0 at edge): state IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers 0, mem_req_o=0, mem_addr_o=0. branch_flag_i is ignored during reset.
- Head outputs are combinational from queue, so there is zero latency from push to visibility on the next cycle.
- pop = if_valid_o & !stall_i. push = mem_done_i in REQ with no flush.
- Simultaneous push and pop at full keeps count unchanged. Push and pop on empty are legal: the head shows the pushed entry next cycle.

FSM (registered mem_req_o/mem_addr_o):
- IDLE: if count<DEPTH, then mem_addr_o<=fetch_pc, mem_req_o<=1, go REQ.
- REQ: hold req and addr. On mem_done_i:
  - push {mem_addr_o, mem_inst_i};
  - fetch_pc<=fetch_pc+PC_STEP, wrapping modulo 2^ADDR_WIDTH;
  - if post-update count<DEPTH, issue the next address immediately (stay REQ, back-to-back fetch);
  - otherwise mem_req_o<=0, go IDLE.
- DROP: keep mem_req_o=1 and the old address. On mem_done_i, discard the data, mem_req_o<=0, go IDLE. Memory is never aborted.

Flush (branch_flag_i=1, highest priority):
- count<=0, pointers reset, fetch_pc<=branch_target_i; no push and no pop that cycle.
- From IDLE: stay IDLE; the next fetch uses the target.
- From REQ without mem_done_i: go DROP.
- From REQ with mem_done_i the same cycle: discard response, mem_req_o<=0, go IDLE.
- From DROP: update fetch_pc only; remain DROP until done.

Other rules:
- A second flush while DROP takes the newer target.
- At most one request outstanding; count<DEPTH at issue guarantees space for the response.
- mem_done_i in IDLE is a protocol error; ignore it.

Decomposition:
- Shared defines file holds the InstAddrBus/InstBus/ZeroWord macros (existing) plus FSM state encodings IF_IDLE/IF_REQ/IF_DROP (2-bit).
- Sub-module if_queue: synchronous FIFO of {pc,inst}, DEPTH entries, with push/pop/clear, count, head outputs, and first-word visible combinationally.

Test Plan:
- Reset then memory replies in 1 cycle, stall_i=0 -> requests at 0x0,0x4,0x8 back-to-back; if_pc_o sequence 0x0,0x4,0x8 with matching insts; stall_req_o=0 once first entry is valid.
- stall_i=1 held, DEPTH=4 -> exactly 4 entries fill, mem_req_o drops to 0 in IDLE. Release stall for 1 cycle -> one pop, one new request at 0x10.
- Branch to 0x100 while REQ for 0x8 pending, done 2 cycles later -> state DROP, 0x8 data never appears, next request addr 0x100, queue empty meanwhile with stall_req_o=1.
- Branch and mem_done_i in the same cycle -> response discarded, next request 0x100 after one IDLE cycle.
- fetch_pc=0xFFFFFFFC fetch completes -> next mem_addr_o=0x00000000.
- rst=0 asserted mid-REQ with queue holding 3 entries -> next cycle mem_req_o=0, if_valid_o=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared types for the prefetching IF stage: bus widths and fetch FSM state encodings.
package if_prefetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_queue.sv
// Prefetch FIFO of {pc, inst} pairs; the head entry is visible combinationally.
module if_queue #(
  parameter  int PC_W   = 32,
  parameter  int INST_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic [CNT_W-1:0]  count,
  output logic              head_vld,
  output logic [PC_W-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst
);

  logic [PC_W+INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Data array needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_pc, push_inst};
  end

  assign head_vld             = (count != '0);
  assign {head_pc, head_inst} = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_prefetch.sv
// Prefetching IF stage: sequential fetch over req/done, DEPTH-entry queue, branch flush.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter  int                    ADDR_WIDTH = INST_ADDR_W,
  parameter  int                    INST_WIDTH = INST_W,
  parameter  int                    DEPTH      = 4,
  parameter  int                    PC_STEP    = 4,
  parameter  logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  localparam int                    CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_done_i,
  input  logic [INST_WIDTH-1:0] mem_inst_i,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  stall_i,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic                  stall_req_o
);

  if_state_e             state, state_nx;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nx, addr_nx;
  logic                  req_nx;
  logic [CNT_W-1:0]      count, count_after;
  logic                  push, pop;

  assign push        = (state == IF_REQ) && mem_done_i && !branch_flag_i;
  assign pop         = if_valid_o && !stall_i && !branch_flag_i;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);
  assign stall_req_o = !if_valid_o;

  if_queue #(.PC_W(ADDR_WIDTH), .INST_W(INST_WIDTH), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (branch_flag_i),
    .push      (push),
    .pop       (pop),
    .push_pc   (mem_addr_o),
    .push_inst (mem_inst_i),
    .count     (count),
    .head_vld  (if_valid_o),
    .head_pc   (if_pc_o),
    .head_inst (if_inst_o)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IF_IDLE;
      fetch_pc   <= RESET_PC;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      state      <= state_nx;
      fetch_pc   <= fetch_pc_nx;
      mem_req_o  <= req_nx;
      mem_addr_o <= addr_nx;
    end
  end

  // A request is never aborted: a flush with one in flight parks in DROP until done.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_nx      = mem_req_o;
    addr_nx     = mem_addr_o;
    if (branch_flag_i) begin
      fetch_pc_nx = branch_target_i;
      case (state)
        IF_REQ, IF_DROP: begin
          if (mem_done_i) begin
            req_nx   = 1'b0;
            state_nx = IF_IDLE;
          end else begin
            state_nx = IF_DROP;
          end
        end
        default: ;
      endcase
    end else begin
      case (state)
        IF_IDLE: begin
          if (count < CNT_W'(DEPTH)) begin
            addr_nx  = fetch_pc;
            req_nx   = 1'b1;
            state_nx = IF_REQ;
          end
        end
        IF_REQ: begin
          if (mem_done_i) begin
            fetch_pc_nx = fetch_pc + ADDR_WIDTH'(PC_STEP);
            if (count_after < CNT_W'(DEPTH)) begin
              addr_nx = fetch_pc_nx;
            end else begin
              req_nx   = 1'b0;
              state_nx = IF_IDLE;
            end
          end
        end
        IF_DROP: begin
          if (mem_done_i) begin
            req_nx   = 1'b0;
            state_nx = IF_IDLE;
          end
        end
        default: begin
          req_nx   = 1'b0;
          state_nx = IF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, fill/stall, flush/drop, PC wrap, reset mid-fetch.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        stall_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stall_req_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_prefetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_done_i      (mem_done_i),
    .mem_inst_i      (mem_inst_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .stall_req_o     (stall_req_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; mem_done_i = 1'b0; mem_inst_i = '0;
    branch_flag_i = 1'b0; branch_target_i = '0;
    step(); step();
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_vld", if_valid_o, 0);
    chk("rst_stall_req", stall_req_o, 1);
    chk("rst_pc", if_pc_o, 0);
    chk("rst_inst", if_inst_o, 0);

    // back-to-back streaming with 1-cycle memory
    rst = 1'b1;
    step();
    chk("s_req0", mem_req_o, 1);
    chk("s_addr0", mem_addr_o, 32'h0);
    chk("s_empty", stall_req_o, 1);
    mem_done_i = 1'b1; mem_inst_i = inst_of(32'h0);
    step();
    chk("s_pc0", if_pc_o, 32'h0);
    chk("s_inst0", if_inst_o, inst_of(32'h0));
    chk("s_stall_req0", stall_req_o, 0);
    chk("s_addr4", mem_addr_o, 32'h4);
    mem_inst_i = inst_of(32'h4);
    step();
    chk("s_pc4", if_pc_o, 32'h4);
    chk("s_inst4", if_inst_o, inst_of(32'h4));
    chk("s_addr8", mem_addr_o, 32'h8);
    mem_inst_i = inst_of(32'h8);
    step();
    chk("s_pc8", if_pc_o, 32'h8);
    chk("s_addrc", mem_addr_o, 32'hC);

    // stall downstream until the queue fills (8, C, 10, 14)
    stall_i = 1'b1; mem_inst_i = inst_of(32'hC);
    step();
    chk("f_head_hold", if_pc_o, 32'h8);
    chk("f_addr10", mem_addr_o, 32'h10);
    mem_inst_i = inst_of(32'h10);
    step();
    chk("f_addr14", mem_addr_o, 32'h14);
    mem_inst_i = inst_of(32'h14);
    step();
    chk("f_full_req", mem_req_o, 0);
    chk("f_full_head", if_pc_o, 32'h8);
    mem_done_i = 1'b0;
    step();
    chk("f_idle_req", mem_req_o, 0);
    stall_i = 1'b0;
    step();
    chk("f_pop_head", if_pc_o, 32'hC);
    chk("f_pop_inst", if_inst_o, inst_of(32'hC));
    chk("f_pop_req", mem_req_o, 0);
    stall_i = 1'b1;
    step();
    chk("f_refill_req", mem_req_o, 1);
    chk("f_refill_addr", mem_addr_o, 32'h18);
    chk("f_refill_head", if_pc_o, 32'hC);

    // flush while a request is outstanding -> DROP
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    chk("d_vld", if_valid_o, 0);
    chk("d_stall_req", stall_req_o, 1);
    chk("d_req_held", mem_req_o, 1);
    chk("d_addr_held", mem_addr_o, 32'h18);
    step();
    chk("d_req_wait", mem_req_o, 1);
    chk("d_addr_wait", mem_addr_o, 32'h18);
    mem_done_i = 1'b1; mem_inst_i = inst_of(32'h18);
    step();
    mem_done_i = 1'b0;
    chk("d_done_req", mem_req_o, 0);
    chk("d_discard", if_valid_o, 0);
    step();
    chk("d_new_req", mem_req_o, 1);
    chk("d_new_addr", mem_addr_o, 32'h100);
    chk("d_still_empty", if_valid_o, 0);

    // flush coincident with done
    mem_done_i = 1'b1; mem_inst_i = inst_of(32'h100);
    branch_flag_i = 1'b1; branch_target_i = 32'h200;
    step();
    mem_done_i = 1'b0; branch_flag_i = 1'b0;
    chk("c_req", mem_req_o, 0);
    chk("c_discard", if_valid_o, 0);
    step();
    chk("c_new_req", mem_req_o, 1);
    chk("c_new_addr", mem_addr_o, 32'h200);

    // fetch PC wraps past the top of the address space
    mem_done_i = 1'b1; mem_inst_i = inst_of(32'h200);
    step();
    mem_done_i = 1'b0;
    chk("w_head200", if_pc_o, 32'h200);
    chk("w_addr204", mem_addr_o, 32'h204);
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    chk("w_flush_vld", if_valid_o, 0);
    mem_done_i = 1'b1; mem_inst_i = inst_of(32'h204);
    step();
    mem_done_i = 1'b0;
    chk("w_drop_req", mem_req_o, 0);
    step();
    chk("w_addr_top", mem_addr_o, 32'hFFFF_FFFC);
    mem_done_i = 1'b1; mem_inst_i = inst_of(32'hFFFF_FFFC);
    step();
    chk("w_addr_wrap", mem_addr_o, 32'h0);
    chk("w_head_top", if_pc_o, 32'hFFFF_FFFC);
    chk("w_inst_top", if_inst_o, inst_of(32'hFFFF_FFFC));

    // three entries queued, request for 0x8 in flight, then reset
    mem_inst_i = inst_of(32'h0);
    step();
    mem_inst_i = inst_of(32'h4);
    step();
    mem_done_i = 1'b0;
    chk("r_pre_addr", mem_addr_o, 32'h8);
    chk("r_pre_head", if_pc_o, 32'hFFFF_FFFC);
    rst = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    step();
    chk("r_req", mem_req_o, 0);
    chk("r_vld", if_valid_o, 0);
    chk("r_addr", mem_addr_o, 0);
    chk("r_stall_req", stall_req_o, 1);
    rst = 1'b1; branch_flag_i = 1'b0;
    step();
    chk("r_restart_req", mem_req_o, 1);
    chk("r_restart_addr", mem_addr_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
